eu_mdu_arbiter: RTL and testbench
=================================

# eu_mdu_arbiter

Shares one multi-cycle multiply/divide unit (MDU) between the way0 and way1 execute-unit register stages. Each cycle it grants the older of the two pending M-extension requests, using the 2-bit program-order ID. It sequences the request/accept/complete handshake with the MDU and returns the result and a pop strobe to the winning way. On a jump it flushes: in-flight work is cancelled and any late result is discarded.

## Interface
Parameters:
- XLEN, 64, operand/result width
- PID_W, 2, program-order ID width

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; synchronous, active-low
- jumpFlag_i  in  1  pipeline flush (branch/jump redirect)
- way0_req_i / way1_req_i  in  1  way has a valid M-type instruction at the head of its EU register
- way0_pID_i / way1_pID_i  in  PID_W  program-order ID of that instruction
- way0_rs1_i, way0_rs2_i / way1_rs1_i, way1_rs2_i  in  XLEN  operands
- way0_funct3_i / way1_funct3_i  in  3  MDU operation select
- way0_word_i / way1_word_i  in  1  RV64 *W variant
- mdu_valid_o  out  1  operation presented to MDU
- mdu_rs1_o, mdu_rs2_o  out  XLEN  latched operands
- mdu_funct3_o  out  3  latched op
- mdu_word_o  out  1  latched W flag
- mdu_ready_i  in  1  MDU accepts the operation
- mdu_done_i  in  1  MDU result valid (single-cycle pulse)
- mdu_result_i  in  XLEN  MDU result
- way0_done_o / way1_done_o  out  1  result strobe; also the pop for that way's EU register
- result_o  out  XLEN  registered result
- busy_o  out  1  state ≠ IDLE

## Operation
- States: IDLE, ISSUE, BUSY, FLUSH.
- IDLE
  - If jumpFlag_i=1: no grant.
  - Otherwise, if any request is pending: select a winner, latch its operands, funct3, word flag and way index into output registers, and go to ISSUE.
- Age rule: d = (way1_pID_i − way0_pID_i) mod 4.
  - way0 wins if d ∈ {0,1,2}; way1 wins if d = 3.
  - With a single request, that requester wins.
- ISSUE
  - mdu_valid_o = 1, with operands held stable.
  - mdu_ready_i=1 → BUSY.
  - jumpFlag_i=1 → IDLE, with mdu_valid_o deasserted on the next cycle. The jump takes priority over a same-cycle mdu_ready_i: go to FLUSH instead of IDLE.
- BUSY
  - mdu_done_i=1 → register mdu_result_i into result_o, pulse the winner's wayX_done_o for one cycle, go to IDLE.
  - jumpFlag_i=1 without done → FLUSH.
  - jumpFlag_i=1 with done in the same cycle → discard the result (no done strobe), go to IDLE.
- FLUSH: wait for mdu_done_i, discard the result, go to IDLE. Further jumps have no effect.
- Only one operation is outstanding; requests are ignored outside IDLE.
- A requester must hold req and its payload until it sees its done strobe or a jump.

## Timing
- Reset (synchronous, reset_n=0 at posedge): state=IDLE. All outputs are 0, including mdu_valid_o, wayX_done_o, result_o, busy_o and the latched fields. Reset asserted mid-operation abandons that operation.
- Latencies:
  - Request in IDLE → mdu_valid_o=1 on the next cycle.
  - mdu_ready_i → BUSY on the next cycle.
  - mdu_done_i at cycle t → wayX_done_o and result_o at t+1.
  - IDLE is re-entered at t+1, so a new grant is possible at t+1 and mdu_valid_o at t+2.
- Back-to-back throughput: one operation per (MDU latency + 2) cycles.
- wayX_done_o is never asserted for both ways in the same cycle, and never in FLUSH.
- Every output is driven by a register; there are no combinational paths from inputs to outputs.

## Structure
- Shared package eu_mdu_pkg holds:
  - the state enum (IDLE, ISSUE, BUSY, FLUSH)
  - PID_W
  - the function pid_older(a, b) that implements the mod-4 age rule; the dispatch logic reuses it.
- One natural sub-module: eu_age_compare, combinational. Inputs are both req/pID pairs; output is the winner index plus a grant-valid bit.
- The rest is a single always_ff FSM plus the operand and result registers.

## Test plan
- Reset: hold reset_n=0 for 2 cycles mid-BUSY → all outputs 0, state IDLE; the next request is granted normally.
- Ordering:
  - Both request, way0_pID=3, way1_pID=0 (d=1) → way0 granted.
  - Repeat with way0_pID=1, way1_pID=0 (d=3) → way1 granted.
  - Equal pIDs → way0 granted.
- Handshake: way1 alone, rs1=7, rs2=6, MUL; hold mdu_ready_i=0 for 3 cycles → mdu_valid_o held with stable operands. Then ready; done with result 42 → way1_done_o=1 and result_o=42 one cycle later; way0_done_o stays 0.
- Flush in BUSY: jumpFlag_i one cycle after accept; done arrives 5 cycles later → no wayX_done_o; busy_o falls the cycle after done.
- Flush in ISSUE: jumpFlag_i while mdu_ready_i=0 → mdu_valid_o=0 next cycle, IDLE, no done strobe.
- Back-to-back: both ways request continuously with MDU latency 4 → grants alternate by pID order; each operation completes in 6 cycles; there are no lost or duplicated done strobes.

Source files
------------

// File: rtl/eu_mdu_pkg.sv
// Shared types and helpers for the execute-unit MDU arbiter.
package eu_mdu_pkg;

  // Program-order ID width; the age rule below assumes a 4-entry ID ring.
  localparam int PID_W    = 2;
  localparam int NUM_WAYS = 2;

  // Arbiter handshake states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    FLUSH = 2'd3
  } mdu_state_e;

  // Returns 1 when instruction 'a' is older than (or the same age as) 'b'.
  // With a 4-entry ID ring, d = (b - a) mod 4 in {0,1,2} means a is older;
  // d = 3 means b is one step behind a in program order, so b is older.
  function automatic logic pid_older(input logic [PID_W-1:0] a,
                                     input logic [PID_W-1:0] b);
    logic [PID_W-1:0] d;
    d = b - a;
    return (d != {PID_W{1'b1}});
  endfunction

endpackage

// File: rtl/eu_age_compare.sv
// Picks the older of the two pending M-extension requests.
module eu_age_compare
  import eu_mdu_pkg::*;
(
  input  logic             req0_i,
  input  logic [PID_W-1:0] pid0_i,
  input  logic             req1_i,
  input  logic [PID_W-1:0] pid1_i,
  output logic             grant_valid_o,
  output logic             winner_o
);

  // Way0 wins ties and whenever it alone requests; way1 wins only when it is
  // strictly older or is the sole requester.
  always_comb begin
    grant_valid_o = req0_i | req1_i;
    winner_o      = 1'b0;
    if (req1_i && (!req0_i || !pid_older(pid0_i, pid1_i))) begin
      winner_o = 1'b1;
    end
  end

endmodule

// File: rtl/eu_mdu_arbiter.sv
// Shares one multi-cycle multiply/divide unit between the two execute ways.
// Grants the older request, runs the valid/ready/done handshake with the MDU
// and returns a registered result plus a one-cycle pop strobe to the winner.
module eu_mdu_arbiter
  import eu_mdu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int PID_W = eu_mdu_pkg::PID_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             jumpFlag_i,

  input  logic             way0_req_i,
  input  logic [PID_W-1:0] way0_pID_i,
  input  logic [XLEN-1:0]  way0_rs1_i,
  input  logic [XLEN-1:0]  way0_rs2_i,
  input  logic [2:0]       way0_funct3_i,
  input  logic             way0_word_i,

  input  logic             way1_req_i,
  input  logic [PID_W-1:0] way1_pID_i,
  input  logic [XLEN-1:0]  way1_rs1_i,
  input  logic [XLEN-1:0]  way1_rs2_i,
  input  logic [2:0]       way1_funct3_i,
  input  logic             way1_word_i,

  output logic             mdu_valid_o,
  output logic [XLEN-1:0]  mdu_rs1_o,
  output logic [XLEN-1:0]  mdu_rs2_o,
  output logic [2:0]       mdu_funct3_o,
  output logic             mdu_word_o,
  input  logic             mdu_ready_i,
  input  logic             mdu_done_i,
  input  logic [XLEN-1:0]  mdu_result_i,

  output logic             way0_done_o,
  output logic             way1_done_o,
  output logic [XLEN-1:0]  result_o,
  output logic             busy_o
);

  mdu_state_e            state_q, state_d;
  logic                  mdu_valid_q, mdu_valid_d;
  logic [XLEN-1:0]       rs1_q, rs1_d;
  logic [XLEN-1:0]       rs2_q, rs2_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  word_q, word_d;
  logic                  win_q, win_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic                  busy_q, busy_d;
  logic [NUM_WAYS-1:0]   way_done_q, way_done_d;

  logic                  grant_valid;
  logic                  winner;
  logic                  complete;

  eu_age_compare u_age_compare (
    .req0_i        (way0_req_i),
    .pid0_i        (way0_pID_i),
    .req1_i        (way1_req_i),
    .pid1_i        (way1_pID_i),
    .grant_valid_o (grant_valid),
    .winner_o      (winner)
  );

  // Next-state, operand latching and result capture for the handshake FSM.
  always_comb begin
    state_d  = state_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    funct3_d = funct3_q;
    word_d   = word_q;
    win_d    = win_q;
    result_d = result_q;
    complete = 1'b0;

    case (state_q)
      IDLE: begin
        // A redirect in the same cycle means the requesters are stale.
        if (!jumpFlag_i && grant_valid) begin
          win_d = winner;
          if (winner) begin
            rs1_d    = way1_rs1_i;
            rs2_d    = way1_rs2_i;
            funct3_d = way1_funct3_i;
            word_d   = way1_word_i;
          end else begin
            rs1_d    = way0_rs1_i;
            rs2_d    = way0_rs2_i;
            funct3_d = way0_funct3_i;
            word_d   = way0_word_i;
          end
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        // If the MDU accepted in the same cycle as the jump, its result will
        // still come back and must be drained in FLUSH.
        if (jumpFlag_i) begin
          state_d = mdu_ready_i ? FLUSH : IDLE;
        end else if (mdu_ready_i) begin
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (mdu_done_i) begin
          state_d = IDLE;
          if (!jumpFlag_i) begin
            complete = 1'b1;
            result_d = mdu_result_i;
          end
        end else if (jumpFlag_i) begin
          state_d = FLUSH;
        end
      end

      FLUSH: begin
        // Cancelled work: swallow the late result; further jumps are moot.
        if (mdu_done_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    mdu_valid_d = (state_d == ISSUE);
    busy_d      = (state_d != IDLE);
  end

  // One pop strobe per way; only the latched winner can see it.
  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way_done
    assign way_done_d[gi] = complete && (win_q == 1'(gi));
  end

  // State and output registers; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mdu_valid_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      funct3_q    <= '0;
      word_q      <= 1'b0;
      win_q       <= 1'b0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      way_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      mdu_valid_q <= mdu_valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      funct3_q    <= funct3_d;
      word_q      <= word_d;
      win_q       <= win_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      way_done_q  <= way_done_d;
    end
  end

  assign mdu_valid_o  = mdu_valid_q;
  assign mdu_rs1_o    = rs1_q;
  assign mdu_rs2_o    = rs2_q;
  assign mdu_funct3_o = funct3_q;
  assign mdu_word_o   = word_q;
  assign result_o     = result_q;
  assign busy_o       = busy_q;
  assign way0_done_o  = way_done_q[0];
  assign way1_done_o  = way_done_q[1];

endmodule

// File: tb/tb_eu_mdu_arbiter.sv
// Directed bench for eu_mdu_arbiter: vector table for age ordering plus
// hand-written sequences for handshake, flush, reset and back-to-back cases.
module tb_eu_mdu_arbiter;

  localparam int XLEN  = 64;
  localparam int PID_W = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             jumpFlag_i;
  logic             way0_req_i, way1_req_i;
  logic [PID_W-1:0] way0_pID_i, way1_pID_i;
  logic [XLEN-1:0]  way0_rs1_i, way0_rs2_i, way1_rs1_i, way1_rs2_i;
  logic [2:0]       way0_funct3_i, way1_funct3_i;
  logic             way0_word_i, way1_word_i;
  logic             mdu_valid_o;
  logic [XLEN-1:0]  mdu_rs1_o, mdu_rs2_o;
  logic [2:0]       mdu_funct3_o;
  logic             mdu_word_o;
  logic             mdu_ready_i, mdu_done_i;
  logic [XLEN-1:0]  mdu_result_i;
  logic             way0_done_o, way1_done_o;
  logic [XLEN-1:0]  result_o;
  logic             busy_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  eu_mdu_arbiter #(.XLEN(XLEN), .PID_W(PID_W)) dut (
    .clk(clk), .reset_n(reset_n), .jumpFlag_i(jumpFlag_i),
    .way0_req_i(way0_req_i), .way0_pID_i(way0_pID_i),
    .way0_rs1_i(way0_rs1_i), .way0_rs2_i(way0_rs2_i),
    .way0_funct3_i(way0_funct3_i), .way0_word_i(way0_word_i),
    .way1_req_i(way1_req_i), .way1_pID_i(way1_pID_i),
    .way1_rs1_i(way1_rs1_i), .way1_rs2_i(way1_rs2_i),
    .way1_funct3_i(way1_funct3_i), .way1_word_i(way1_word_i),
    .mdu_valid_o(mdu_valid_o), .mdu_rs1_o(mdu_rs1_o), .mdu_rs2_o(mdu_rs2_o),
    .mdu_funct3_o(mdu_funct3_o), .mdu_word_o(mdu_word_o),
    .mdu_ready_i(mdu_ready_i), .mdu_done_i(mdu_done_i),
    .mdu_result_i(mdu_result_i),
    .way0_done_o(way0_done_o), .way1_done_o(way1_done_o),
    .result_o(result_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [1:0] p0;
    logic [1:0] p1;
    logic       exp_w1;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic r, input logic [1:0] p, input logic [63:0] a,
                        input logic [63:0] b, input logic [2:0] f, input logic w);
    way0_req_i = r; way0_pID_i = p; way0_rs1_i = a; way0_rs2_i = b;
    way0_funct3_i = f; way0_word_i = w;
  endtask

  task automatic drive1(input logic r, input logic [1:0] p, input logic [63:0] a,
                        input logic [63:0] b, input logic [2:0] f, input logic w);
    way1_req_i = r; way1_pID_i = p; way1_rs1_i = a; way1_rs2_i = b;
    way1_funct3_i = f; way1_word_i = w;
  endtask

  task automatic drop_reqs();
    way0_req_i = 1'b0;
    way1_req_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] last_result;
    logic [63:0] res;
    logic [63:0] e_rs1, e_rs2;
    logic [2:0]  e_f3;
    logic        e_w;
    int          w0_idx, w1_idx, last_valid_cyc, n;
    logic        exp_w1;

    // Age-ordering vectors: {req0, req1, pid0, pid1, way1 expected to win}
    vecs[0] = '{1'b1, 1'b1, 2'd3, 2'd0, 1'b0}; // d=1
    vecs[1] = '{1'b1, 1'b1, 2'd1, 2'd0, 1'b1}; // d=3
    vecs[2] = '{1'b1, 1'b1, 2'd2, 2'd2, 1'b0}; // equal
    vecs[3] = '{1'b1, 1'b0, 2'd0, 2'd3, 1'b0}; // way0 alone
    vecs[4] = '{1'b0, 1'b1, 2'd2, 2'd0, 1'b1}; // way1 alone
    vecs[5] = '{1'b1, 1'b1, 2'd0, 2'd3, 1'b1}; // d=3
    vecs[6] = '{1'b1, 1'b1, 2'd0, 2'd2, 1'b0}; // d=2
    vecs[7] = '{1'b1, 1'b1, 2'd3, 2'd2, 1'b1}; // d=3 wrapped

    reset_n = 1'b0; jumpFlag_i = 1'b0;
    mdu_ready_i = 1'b0; mdu_done_i = 1'b0; mdu_result_i = '0;
    drive0(1'b0, 2'd0, '0, '0, 3'd0, 1'b0);
    drive1(1'b0, 2'd0, '0, '0, 3'd0, 1'b0);
    last_result = '0;

    // ---- reset state
    step(); step();
    chk("rst_valid", 64'(mdu_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_done", {62'd0, way1_done_o, way0_done_o}, 64'd0);
    reset_n = 1'b1;
    step();

    // ---- table-driven ordering transactions
    for (int i = 0; i < 8; i++) begin
      drive0(vecs[i].r0, vecs[i].p0, 64'h100 + 64'(i), 64'h1000 + 64'(i), 3'd1, 1'b0);
      drive1(vecs[i].r1, vecs[i].p1, 64'h200 + 64'(i), 64'h2000 + 64'(i), 3'd4, 1'b1);
      e_rs1 = vecs[i].exp_w1 ? 64'h200 + 64'(i) : 64'h100 + 64'(i);
      e_rs2 = vecs[i].exp_w1 ? 64'h2000 + 64'(i) : 64'h1000 + 64'(i);
      e_f3  = vecs[i].exp_w1 ? 3'd4 : 3'd1;
      e_w   = vecs[i].exp_w1;
      res   = 64'hA000 + 64'(i);
      step();
      chk("vec_valid", 64'(mdu_valid_o), 64'd1);
      chk("vec_rs1", mdu_rs1_o, e_rs1);
      chk("vec_rs2", mdu_rs2_o, e_rs2);
      chk("vec_funct3", 64'(mdu_funct3_o), 64'(e_f3));
      chk("vec_word", 64'(mdu_word_o), 64'(e_w));
      chk("vec_busy", 64'(busy_o), 64'd1);
      mdu_ready_i = 1'b1;
      step();
      mdu_ready_i = 1'b0;
      chk("vec_valid_drop", 64'(mdu_valid_o), 64'd0);
      step(); step();
      mdu_done_i = 1'b1; mdu_result_i = res;
      step();
      mdu_done_i = 1'b0;
      chk("vec_way0_done", 64'(way0_done_o), 64'(!vecs[i].exp_w1));
      chk("vec_way1_done", 64'(way1_done_o), 64'(vecs[i].exp_w1));
      chk("vec_result", result_o, res);
      chk("vec_busy_idle", 64'(busy_o), 64'd0);
      $display("txn vec%0d way0_done=%0b way1_done=%0b result=%0h", i, way0_done_o, way1_done_o, result_o);
      drop_reqs();
      step();
      chk("vec_done_pulse", {62'd0, way1_done_o, way0_done_o}, 64'd0);
      last_result = res;
    end

    // ---- handshake: way1 alone, MUL 7*6, ready held low 3 cycles
    drive1(1'b1, 2'd1, 64'd7, 64'd6, 3'd0, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("hs_valid_hold", 64'(mdu_valid_o), 64'd1);
      chk("hs_rs1_hold", mdu_rs1_o, 64'd7);
      chk("hs_rs2_hold", mdu_rs2_o, 64'd6);
      step();
    end
    chk("hs_valid_hold", 64'(mdu_valid_o), 64'd1);
    mdu_ready_i = 1'b1;
    step();
    mdu_ready_i = 1'b0;
    step();
    mdu_done_i = 1'b1; mdu_result_i = 64'd42;
    step();
    mdu_done_i = 1'b0;
    chk("hs_way1_done", 64'(way1_done_o), 64'd1);
    chk("hs_way0_done", 64'(way0_done_o), 64'd0);
    chk("hs_result", result_o, 64'd42);
    $display("txn handshake way1_done=%0b result=%0d", way1_done_o, result_o);
    last_result = 64'd42;
    drop_reqs();
    step();
    chk("hs_done_pulse", 64'(way1_done_o), 64'd0);

    // ---- flush in BUSY; a second jump during FLUSH must be ignored
    drive0(1'b1, 2'd0, 64'd3, 64'd4, 3'd0, 1'b0);
    step();
    mdu_ready_i = 1'b1;
    step();
    mdu_ready_i = 1'b0; jumpFlag_i = 1'b1;
    step();
    jumpFlag_i = 1'b0; drop_reqs();
    chk("fb_busy", 64'(busy_o), 64'd1);
    chk("fb_valid", 64'(mdu_valid_o), 64'd0);
    for (int k = 0; k < 4; k++) begin
      jumpFlag_i = (k == 1);
      step();
      chk("fb_no_done", {62'd0, way1_done_o, way0_done_o}, 64'd0);
      chk("fb_busy_wait", 64'(busy_o), 64'd1);
    end
    jumpFlag_i = 1'b0;
    mdu_done_i = 1'b1; mdu_result_i = 64'd99;
    step();
    mdu_done_i = 1'b0;
    chk("fb_no_done_end", {62'd0, way1_done_o, way0_done_o}, 64'd0);
    chk("fb_busy_fall", 64'(busy_o), 64'd0);
    chk("fb_result_kept", result_o, last_result);
    $display("txn flush_busy busy=%0b result=%0d", busy_o, result_o);

    // ---- flush in ISSUE with ready low
    drive0(1'b1, 2'd1, 64'd5, 64'd5, 3'd0, 1'b0);
    step();
    chk("fi_valid", 64'(mdu_valid_o), 64'd1);
    jumpFlag_i = 1'b1; drop_reqs();
    step();
    jumpFlag_i = 1'b0;
    chk("fi_valid_drop", 64'(mdu_valid_o), 64'd0);
    chk("fi_busy", 64'(busy_o), 64'd0);
    step();
    chk("fi_no_done", {62'd0, way1_done_o, way0_done_o}, 64'd0);
    $display("txn flush_issue valid=%0b busy=%0b", mdu_valid_o, busy_o);

    // ---- jump together with ready in ISSUE: must drain the result in FLUSH
    drive1(1'b1, 2'd2, 64'd8, 64'd9, 3'd0, 1'b0);
    step();
    jumpFlag_i = 1'b1; mdu_ready_i = 1'b1; drop_reqs();
    step();
    jumpFlag_i = 1'b0; mdu_ready_i = 1'b0;
    chk("jr_busy", 64'(busy_o), 64'd1);
    chk("jr_valid", 64'(mdu_valid_o), 64'd0);
    mdu_done_i = 1'b1; mdu_result_i = 64'd77;
    step();
    mdu_done_i = 1'b0;
    chk("jr_no_done", {62'd0, way1_done_o, way0_done_o}, 64'd0);
    chk("jr_result_kept", result_o, last_result);
    chk("jr_busy_fall", 64'(busy_o), 64'd0);
    $display("txn jump_ready busy=%0b result=%0d", busy_o, result_o);

    // ---- jump together with done in BUSY: result discarded
    drive0(1'b1, 2'd3, 64'd11, 64'd12, 3'd0, 1'b0);
    step();
    mdu_ready_i = 1'b1;
    step();
    mdu_ready_i = 1'b0;
    step();
    mdu_done_i = 1'b1; jumpFlag_i = 1'b1; mdu_result_i = 64'd55;
    step();
    mdu_done_i = 1'b0; jumpFlag_i = 1'b0; drop_reqs();
    chk("jd_no_done", {62'd0, way1_done_o, way0_done_o}, 64'd0);
    chk("jd_result_kept", result_o, last_result);
    chk("jd_busy", 64'(busy_o), 64'd0);
    $display("txn jump_done busy=%0b result=%0d", busy_o, result_o);

    // ---- jump in IDLE blocks the grant
    drive0(1'b1, 2'd0, 64'd1, 64'd1, 3'd0, 1'b0);
    jumpFlag_i = 1'b1;
    step();
    chk("ji_no_grant", 64'(mdu_valid_o), 64'd0);
    chk("ji_busy", 64'(busy_o), 64'd0);
    jumpFlag_i = 1'b0; drop_reqs();
    step();
    $display("txn jump_idle valid=%0b", mdu_valid_o);

    // ---- reset for 2 cycles in the middle of BUSY, then a normal grant
    drive1(1'b1, 2'd2, 64'hA5, 64'h5A, 3'd5, 1'b1);
    step();
    mdu_ready_i = 1'b1;
    step();
    mdu_ready_i = 1'b0;
    reset_n = 1'b0;
    step(); step();
    chk("mr_valid", 64'(mdu_valid_o), 64'd0);
    chk("mr_busy", 64'(busy_o), 64'd0);
    chk("mr_result", result_o, 64'd0);
    chk("mr_rs1", mdu_rs1_o, 64'd0);
    chk("mr_rs2", mdu_rs2_o, 64'd0);
    chk("mr_fields", {60'd0, mdu_funct3_o, mdu_word_o}, 64'd0);
    chk("mr_done", {62'd0, way1_done_o, way0_done_o}, 64'd0);
    reset_n = 1'b1;
    step();
    chk("mr_regrant_valid", 64'(mdu_valid_o), 64'd1);
    chk("mr_regrant_rs1", mdu_rs1_o, 64'hA5);
    mdu_ready_i = 1'b1;
    step();
    mdu_ready_i = 1'b0;
    mdu_done_i = 1'b1; mdu_result_i = 64'h1234;
    step();
    mdu_done_i = 1'b0; drop_reqs();
    chk("mr_way1_done", 64'(way1_done_o), 64'd1);
    chk("mr_result_new", result_o, 64'h1234);
    $display("txn reset_mid_busy way1_done=%0b result=%0h", way1_done_o, result_o);
    step();

    // ---- back-to-back: both ways request continuously, MDU latency 4
    w0_idx = 0; w1_idx = 1; last_valid_cyc = 0;
    drive0(1'b1, 2'(w0_idx), 64'(w0_idx), 64'd2, 3'd0, 1'b0);
    drive1(1'b1, 2'(w1_idx), 64'(w1_idx), 64'd3, 3'd0, 1'b0);
    for (int op = 0; op < 6; op++) begin
      n = 0;
      while (!mdu_valid_o && n < 10) begin
        step();
        n++;
      end
      chk("b2b_valid", 64'(mdu_valid_o), 64'd1);
      chk("b2b_no_extra_done", {62'd0, way1_done_o, way0_done_o}, 64'd0);
      if (op > 0) chk("b2b_period", 64'(cyc - last_valid_cyc), 64'd6);
      last_valid_cyc = cyc;
      exp_w1 = (w1_idx < w0_idx);
      e_rs1  = exp_w1 ? 64'(w1_idx) : 64'(w0_idx);
      chk("b2b_rs1", mdu_rs1_o, e_rs1);
      mdu_ready_i = 1'b1;
      step();
      mdu_ready_i = 1'b0;
      step(); step(); step();
      mdu_done_i = 1'b1; mdu_result_i = e_rs1 * 10 + 5;
      step();
      mdu_done_i = 1'b0;
      chk("b2b_way0_done", 64'(way0_done_o), 64'(!exp_w1));
      chk("b2b_way1_done", 64'(way1_done_o), 64'(exp_w1));
      chk("b2b_result", result_o, e_rs1 * 10 + 5);
      $display("txn b2b%0d way0_done=%0b way1_done=%0b result=%0d", op, way0_done_o, way1_done_o, result_o);
      if (exp_w1) begin
        w1_idx += 2;
        drive1(1'b1, 2'(w1_idx), 64'(w1_idx), 64'd3, 3'd0, 1'b0);
      end else begin
        w0_idx += 2;
        drive0(1'b1, 2'(w0_idx), 64'(w0_idx), 64'd2, 3'd0, 1'b0);
      end
    end
    drop_reqs();
    step();
    chk("b2b_tail_done", {62'd0, way1_done_o, way0_done_o}, 64'd0);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
